// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin packet arbiter sharing one data bus among NUM_REQ sources
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-requester packet request (level)
//   data_in    flattened requester words, requester i on [i*BUS_SIZE +: BUS_SIZE]
//   error      downstream checker error; aborts the packet in flight
//   grant      one-hot registered grant; requester advances one word per grant cycle
//   data_bus   registered forwarded word, 0 when bus_valid is low
//   bus_valid  data_bus carries a packet word
//   pkt_done   one-cycle pulse with the last word of a completed packet
//   abort_cnt  aborted packet count, saturating at 255
module packet_arbiter #(
  parameter int BUS_SIZE   = 16,
  parameter int WORD_SIZE  = 4,
  parameter int WORD_NUM   = BUS_SIZE / WORD_SIZE,
  parameter int NUM_REQ    = 4,
  parameter int PKT_LEN    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*BUS_SIZE-1:0] data_in,
  input  logic                        error,
  output logic [NUM_REQ-1:0]          grant,
  output logic [BUS_SIZE-1:0]         data_bus,
  output logic                        bus_valid,
  output logic                        pkt_done,
  output logic [7:0]                  abort_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [3:0]           word_cnt, word_cnt_nxt;
  logic [2:0]           gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [BUS_SIZE-1:0]  data_bus_nxt;
  logic                 bus_valid_nxt;
  logic                 pkt_done_nxt;
  logic [7:0]           abort_cnt_nxt;

  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     cand;
  logic [BUS_SIZE-1:0]  sel_word;

  // (p + k) mod NUM_REQ for 1 <= k <= NUM_REQ
  function automatic logic [PTR_W-1:0] ring_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan from the farthest position back toward rr_ptr+1 so the last hit
  // is the nearest requester after the previous winner.
  always_comb begin
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ring_add(rr_ptr, k);
      if (req[cand]) winner = cand;
    end
  end

  // Granted requester's word, copied lane by lane so the sub-word layout
  // seen downstream matches the source slice exactly.
  always_comb begin
    sel_word = '0;
    for (int w = 0; w < WORD_NUM; w++) begin
      sel_word[w*WORD_SIZE +: WORD_SIZE] =
        data_in[int'(rr_ptr)*BUS_SIZE + w*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    word_cnt_nxt  = word_cnt;
    gap_cnt_nxt   = gap_cnt;
    grant_nxt     = grant;
    data_bus_nxt  = '0;
    bus_valid_nxt = 1'b0;
    pkt_done_nxt  = 1'b0;
    abort_cnt_nxt = abort_cnt;

    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (|req) begin
          grant_nxt[winner] = 1'b1;
          rr_ptr_nxt        = winner;
          word_cnt_nxt      = '0;
          state_nxt         = SEND;
        end
      end

      SEND: begin
        // Error wins over capture/completion; rr_ptr stays on the aborted
        // requester so it gets no retry priority.
        if (error) begin
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
          if (abort_cnt != 8'hFF) abort_cnt_nxt = abort_cnt + 8'd1;
        end else begin
          data_bus_nxt  = sel_word;
          bus_valid_nxt = 1'b1;
          word_cnt_nxt  = word_cnt + 4'd1;
          if (word_cnt == 4'(PKT_LEN - 1)) begin
            grant_nxt    = '0;
            pkt_done_nxt = 1'b1;
            gap_cnt_nxt  = '0;
            state_nxt    = GAP;
          end
        end
      end

      GAP: begin
        grant_nxt   = '0;
        gap_cnt_nxt = gap_cnt + 3'd1;
        if (gap_cnt == 3'(GAP_CYCLES - 1)) state_nxt = IDLE;
      end

      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      word_cnt  <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      data_bus  <= '0;
      bus_valid <= 1'b0;
      pkt_done  <= 1'b0;
      abort_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      word_cnt  <= word_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      grant     <= grant_nxt;
      data_bus  <= data_bus_nxt;
      bus_valid <= bus_valid_nxt;
      pkt_done  <= pkt_done_nxt;
      abort_cnt <= abort_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - self-checking bench for packet_arbiter
module tb_packet_arbiter;
  localparam int BUS_SIZE   = 16;
  localparam int NUM_REQ    = 4;
  localparam int PKT_LEN    = 4;
  localparam int GAP_CYCLES = 1;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [NUM_REQ-1:0]          req = '0;
  logic [NUM_REQ*BUS_SIZE-1:0] data_in = '0;
  logic                        error = 1'b0;
  logic [NUM_REQ-1:0]          grant;
  logic [BUS_SIZE-1:0]         data_bus;
  logic                        bus_valid;
  logic                        pkt_done;
  logic [7:0]                  abort_cnt;

  packet_arbiter #(
    .BUS_SIZE(BUS_SIZE), .WORD_SIZE(4), .WORD_NUM(BUS_SIZE/4),
    .NUM_REQ(NUM_REQ), .PKT_LEN(PKT_LEN), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .error(error),
    .grant(grant), .data_bus(data_bus), .bus_valid(bus_valid),
    .pkt_done(pkt_done), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Requesters: word k of requester i; each advances after a cycle with its grant high.
  function automatic logic [15:0] word_of(input int i, input int k);
    if (i == 0) return (k == 0) ? 16'hF001 : 16'(k * 16'h1111);
    return 16'(16'hA000 + i * 256 + k);
  endfunction

  int idx [NUM_REQ];
  logic [NUM_REQ-1:0] grant_prev = '0;

  initial for (int i = 0; i < NUM_REQ; i++) idx[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_prev[i]) idx[i] = idx[i] + 1;
      data_in[i*BUS_SIZE +: BUS_SIZE] = word_of(i, idx[i]);
    end
    grant_prev = grant;
  end

  // Timeline model: a packet starts at arbitration edge s, moves words on
  // edges s+1..s+PKT_LEN, and the next arbitration is allowed GAP_CYCLES+1
  // edges after the packet ends (by completion or abort).
  int n = 0;
  bit m_ok = 0;
  bit m_active = 0;
  bit m_found;
  int m_rr, m_owner, m_start, m_next_arb, m_c;
  logic [NUM_REQ-1:0]  e_grant = '0;
  logic [BUS_SIZE-1:0] e_bus = '0;
  logic                e_valid = 0, e_done = 0;
  int                  e_abort = 0;

  always @(posedge clk) begin
    n = n + 1;
    if (reset) begin
      e_grant = '0; e_bus = '0; e_valid = 0; e_done = 0; e_abort = 0;
      m_rr = NUM_REQ - 1; m_active = 0; m_next_arb = n + 1; m_ok = 1;
    end else if (m_active) begin
      if (error) begin
        e_grant = '0; e_bus = '0; e_valid = 0; e_done = 0;
        if (e_abort < 255) e_abort = e_abort + 1;
        m_active = 0; m_next_arb = n + GAP_CYCLES + 1;
      end else begin
        e_bus = data_in[m_owner*BUS_SIZE +: BUS_SIZE];
        e_valid = 1; e_done = 0;
        if (n == m_start + PKT_LEN) begin
          e_grant = '0; e_done = 1; m_active = 0; m_next_arb = n + GAP_CYCLES + 1;
        end
      end
    end else begin
      e_grant = '0; e_bus = '0; e_valid = 0; e_done = 0;
      if (n >= m_next_arb && req != 0) begin
        m_found = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_c = (m_rr + k) % NUM_REQ;
          if (!m_found && req[m_c]) begin m_owner = m_c; m_found = 1; end
        end
        m_rr = m_owner; m_start = n; m_active = 1;
        e_grant = NUM_REQ'(1 << m_owner);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("m_grant", grant, e_grant);
      check("m_data_bus", data_bus, e_bus);
      check("m_bus_valid", bus_valid, e_valid);
      check("m_pkt_done", pkt_done, e_done);
      check("m_abort_cnt", abort_cnt, e_abort[7:0]);
    end
  end

  // Grant-sequence collector
  logic [NUM_REQ-1:0] gseq [$];
  int glen [$];
  int glow [$];

  task automatic collect(input int ncyc);
    logic [NUM_REQ-1:0] g, prev;
    int run, low;
    gseq.delete(); glen.delete(); glow.delete();
    prev = '0; run = 0; low = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      g = grant;
      if (g != prev) begin
        if (prev != 0) glen.push_back(run);
        if (g != 0) begin gseq.push_back(g); glow.push_back(low); end
        run = 0; low = 0;
      end
      if (g != 0) run++; else low++;
      prev = g;
    end
  endtask

  task automatic wait_grant(input string name, input int maxc);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (grant != 0) return;
    end
    checks++; failures++;
    $display("FAIL %s timeout actual=0 expected=nonzero grant", name);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0]  t1_g [7];
  logic        t1_v [7];
  logic        t1_p [7];
  logic [15:0] t1_d [7];
  int nv;
  bit seen_done;

  initial begin
    t1_g = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
    t1_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t1_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t1_d = '{16'h0, 16'hF001, 16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0};

    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_data_bus", data_bus, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_abort_cnt", abort_cnt, 0);

    // single requester packet
    reset = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("t1_grant[%0d]", c + 1), grant, t1_g[c]);
      check($sformatf("t1_valid[%0d]", c + 1), bus_valid, t1_v[c]);
      check($sformatf("t1_done[%0d]", c + 1), pkt_done, t1_p[c]);
      check($sformatf("t1_data[%0d]", c + 1), data_bus, t1_d[c]);
    end
    req = 4'b0000;
    repeat (8) @(negedge clk);

    // all requesting: rotation 1,2,4,8,1
    pulse_reset();
    req = 4'b1111;
    collect(40);
    check("t2_count", 32'(gseq.size() >= 5), 1);
    if (gseq.size() >= 5) begin
      check("t2_seq0", gseq[0], 4'b0001);
      check("t2_seq1", gseq[1], 4'b0010);
      check("t2_seq2", gseq[2], 4'b0100);
      check("t2_seq3", gseq[3], 4'b1000);
      check("t2_seq4", gseq[4], 4'b0001);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_len%0d", i), glen[i], PKT_LEN);
        check($sformatf("t2_low%0d", i + 1), glow[i + 1], GAP_CYCLES + 1);
      end
    end

    // only 2 and 0 requesting after a grant to 2
    req = 4'b0000;
    pulse_reset();
    req = 4'b0100;
    wait_grant("t3_first", 10);
    check("t3_first_grant", grant, 4'b0100);
    req = 4'b0101;
    collect(30);
    check("t3_count", 32'(gseq.size() >= 4), 1);
    for (int i = 0; i < gseq.size(); i++)
      check($sformatf("t3_seq%0d", i), gseq[i], (i % 2 == 0) ? 4'b0100 : 4'b0001);

    // abort on grant cycle 2 of requester 1
    req = 4'b0000;
    pulse_reset();
    req = 4'b0010;
    wait_grant("t4_first", 10);
    check("t4_first_grant", grant, 4'b0010);
    req = 4'b1111;
    nv = 0; seen_done = 0;
    @(negedge clk); nv += int'(bus_valid); seen_done |= pkt_done;
    @(negedge clk); nv += int'(bus_valid); seen_done |= pkt_done;
    error = 1'b1;
    @(negedge clk); nv += int'(bus_valid); seen_done |= pkt_done;
    error = 1'b0;
    check("t4_words", nv, 2);
    check("t4_no_done", seen_done, 0);
    check("t4_valid_after", bus_valid, 0);
    check("t4_grant_after", grant, 0);
    check("t4_abort_cnt", abort_cnt, 1);
    wait_grant("t4_next", 10);
    check("t4_next_grant", grant, 4'b0100);

    // reset during word 3 of that packet
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_grant", grant, 0);
    check("t5_valid", bus_valid, 0);
    check("t5_data", data_bus, 0);
    check("t5_abort", abort_cnt, 0);
    reset = 1'b0;
    wait_grant("t5_next", 10);
    check("t5_next_grant", grant, 4'b0001);

    // abort counter saturation
    req = 4'b0000;
    pulse_reset();
    req = 4'b0001;
    error = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_abort_30", abort_cnt, 10);
    repeat (770) @(negedge clk);
    check("t6_abort_sat", abort_cnt, 255);
    repeat (30) @(negedge clk);
    check("t6_abort_hold", abort_cnt, 255);
    error = 1'b0;
    req = 4'b0000;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_arbiter.md
Name: packet_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single BUS_SIZE data_bus among NUM_REQ packet sources.
- data_bus feeds the protocol-checking state machine and the per-word generate/control datapath.
- Grants one requester per packet, forwards exactly PKT_LEN words, and enforces an idle gap between packets.
- Aborts the current packet when the downstream checker flags an error.

Parameters:
- BUS_SIZE, 16, width of one bus word.
- WORD_SIZE, 4, width of a sub-word nibble; informational, kept for consistency with downstream blocks.
- WORD_NUM, BUS_SIZE/WORD_SIZE, sub-words per bus word.
- NUM_REQ, 4, number of requesters (2..8).
- PKT_LEN, 4, words per packet (2..15).
- GAP_CYCLES, 1, forced idle cycles after each packet (1..7).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester packet request; level-sensitive.
- data_in  input  NUM_REQ*BUS_SIZE  flattened words; requester i drives bits [i*BUS_SIZE +: BUS_SIZE].
- error  input  1  downstream checker error flag.
- grant  output  NUM_REQ  one-hot registered grant. Requester advances to its next word on every cycle it sees its grant bit high.
- data_bus  output  BUS_SIZE  registered forwarded word; 0 when not valid.
- bus_valid  output  1  data_bus carries a packet word.
- pkt_done  output  1  one-cycle pulse aligned with the last word of a completed packet.
- abort_cnt  output  8  number of aborted packets; saturates at 255.

Behaviour:
- States: IDLE, SEND, GAP. Reset (sync, at clk edge with reset=1), regardless of current state:
  - state=IDLE; grant=0, data_bus=0, bus_valid=0, pkt_done=0, abort_cnt=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority; word_cnt=0; gap_cnt=0.
- IDLE:
  - bus_valid=0, data_bus=0.
  - If req!=0 at an edge: winner = first set req bit searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - That edge: grant<=onehot(winner), rr_ptr<=winner, word_cnt<=0, state<=SEND.
  - If req==0: stay in IDLE.
- SEND, each edge with error=0:
  - data_bus<=data_in[winner slice], bus_valid<=1, word_cnt++.
  - When word_cnt==PKT_LEN-1 at that edge: grant<=0, pkt_done<=1, gap_cnt<=0, state<=GAP.
  - grant is therefore high exactly PKT_LEN cycles; data_bus/bus_valid lag grant by 1 cycle.
  - Words on the bus: data_in sampled during grant cycles 0..PKT_LEN-1.
- SEND, edge with error=1 (takes priority over word capture and completion):
  - grant<=0, bus_valid<=0, data_bus<=0, pkt_done<=0.
  - abort_cnt<=abort_cnt+1 (holds at 255); state<=GAP.
  - rr_ptr remains at the aborted requester, so that requester gets no retry priority.
- error is ignored in IDLE and GAP.
- req deassertion during SEND is ignored; a packet, once granted, runs to completion or abort.
- GAP:
  - bus_valid=0, data_bus=0, grant=0; pkt_done returns to 0 after its single cycle.
  - gap_cnt increments each cycle; after GAP_CYCLES cycles, state<=IDLE.
  - Arbitration occurs at the first IDLE edge, so grant is low for GAP_CYCLES+1 cycles between consecutive grants.
- Simultaneous requests: resolved purely by rr_ptr order; no fixed priority beyond reset.
- grant is never multi-hot. data_bus is 0 whenever bus_valid=0.
- Reset asserted mid-SEND: the packet is dropped with no pkt_done and no abort_cnt increment; all outputs reach reset values at that edge.

Test Plan:
- Reset, then req=0001, data_in[0] supplies words 0xF001,0x1111,0x2222,0x3333 (PKT_LEN=4):
  - grant=0001 for 4 cycles starting 1 cycle after req.
  - bus_valid high 4 cycles, 1 cycle later, carrying those words in order.
  - pkt_done high with 0x3333; then 2 idle cycles before the next grant can rise.
- req=1111 held constant: grant sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 4 cycles, separated by 2 low cycles.
- Only req[2] and req[0] held, after a grant to 2: next grant is 0001, then 0100; requesters 1 and 3 are never granted.
- error=1 on grant cycle 2 of a packet from requester 1:
  - Bus carries 2 words, then bus_valid=0 with no pkt_done; abort_cnt 0→1.
  - Next arbitration starts the search from requester 2.
- reset pulsed for one cycle during word 3: next cycle grant=0, bus_valid=0, data_bus=0, abort_cnt=0; after reset, requester 0 wins when req=1111.
- 256 consecutive error aborts: abort_cnt saturates at 255 and stays there.
